german_rule_sched: RTL and testbench
====================================

Name: german_rule_sched

Overview:
- Rule-enable generator sitting directly upstream of the German coherence `system` model.
- Drives the `system` 5-bit `io_en_a` rule-select input once per clock.
- Sequences come from one of three sources: round-robin sweep, LFSR pseudo-random, or replay of a loaded trace.
- Used to drive directed and random runs of the Chisel model for equivalence and regression.

Parameters:
- NUM_RULES, 20, number of valid rule indices 0..NUM_RULES-1 (1..31).
- NOP_CODE, 31, rule index emitted when idle; must be >= NUM_RULES.
- DEPTH, 16, trace buffer entries (power of two, 2..64).
- LFSR_SEED, 8'hA5, nonzero reset/restart value of the 8-bit LFSR.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- io_mode  input  2  source select, sampled at start: 0 round-robin, 1 LFSR, 2 replay, 3 treated as 0.
- io_steps  input  16  run length, sampled at start; 0 = unbounded.
- io_start  input  1  begin run; honoured only in IDLE.
- io_stop  input  1  abort run; honoured in RUN.
- io_load_valid  input  1  trace write request.
- io_load_data  input  5  trace entry.
- io_load_ready  output  1  high only in IDLE with buffer not full.
- io_en_a  output  5  registered rule select to `system`.
- io_busy  output  1  high in RUN.
- io_done  output  1  one-cycle pulse on RUN->IDLE.
- io_count  output  16  steps issued in current/last run.

Behaviour:
- Clock and reset:
  - Asynchronous, active-high reset; single clock domain.
- Reset values:
  - State IDLE.
  - `io_en_a` = NOP_CODE.
  - `io_busy` = 0, `io_done` = 0, `io_count` = 0.
  - Trace length = 0, write pointer = 0, LFSR = LFSR_SEED.
  - `io_load_ready` = 1 once reset deasserts.
- States: IDLE, RUN.
- IDLE:
  - `io_en_a` holds NOP_CODE.
  - Load handshake: each cycle with `io_load_valid` && `io_load_ready` writes `io_load_data` at the write pointer, then increments pointer and length.
  - At length == DEPTH, `io_load_ready` = 0 and further writes are ignored.
  - Buffer contents are cleared only by reset.
- IDLE->RUN (`io_start` at cycle t):
  - Sample mode and steps; clear `io_count`.
  - Reset round-robin index to 0, replay pointer to 0, and LFSR to LFSR_SEED.
  - First rule appears on `io_en_a` at t+1 (latency 1).
- Start with replay mode and length 0: no RUN; `io_done` pulses at t+1; `io_en_a` stays NOP_CODE.
- RUN, each cycle:
  - Register next rule into `io_en_a`; `io_count` += 1 (saturates at 16'hFFFF).
  - Round-robin: 0,1,..,NUM_RULES-1, wrap to 0.
  - LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1, advances every RUN cycle. Emit lfsr[4:0] if < NUM_RULES, else emit NOP_CODE; the NOP cycle still counts as a step.
  - Replay: emit buffer[ptr], ptr += 1; the trace does not wrap.
- RUN exit:
  - Terminal step = count reaches steps (steps != 0), or the replay pointer reaches length.
  - Next cycle after the terminal step: state IDLE, `io_en_a` = NOP_CODE, `io_done` = 1 for one cycle.
  - With steps != 0, replay issues min(steps, length) entries.
- `io_stop` in RUN: next cycle `io_en_a` = NOP_CODE, IDLE, `io_done` pulses; the rule issued on the stop cycle counts.
- `io_stop` and the terminal step in the same cycle: identical result, single `io_done` pulse.
- `io_start` in RUN is ignored.
- `io_start` and `io_load_valid` together in IDLE: the load is accepted and start is taken; the new entry is included in the replay length.
- Load attempts in RUN: `io_load_ready` = 0, no write.
- Reset mid-run: immediate IDLE with all reset values; trace is lost.

Test Plan:
- Reset asserted mid-cycle during RUN → `io_en_a` = 31, `io_busy` = 0, `io_count` = 0 asynchronously; `io_load_ready` = 1 once reset drops.
- mode 0, steps 22, start → `io_en_a` sequence 0..19, 0, 1 on cycles t+1..t+22; `io_done` at t+23 with `io_en_a` = 31, `io_count` = 22.
- Load 3, 0, 8, then mode 2, steps 0, start → `io_en_a` = 3, 0, 8, then 31 with `io_done`; `io_count` = 3.
- Load 16 entries → `io_load_ready` drops after the 16th accept; a 17th valid is ignored, and replay emits exactly the 16 loaded values.
- mode 1, steps 10 → first outputs follow the LFSR model from seed 0xA5; values >= 20 appear as 31; `io_count` = 10.
- mode 0, steps 0, `io_stop` asserted at run cycle 5 → outputs 0..4, then 31 with `io_done`; `io_count` = 5; start with replay mode and empty buffer → `io_done` next cycle, `io_busy` never set.

Source files
------------

// File: rtl/german_rule_sched_if.sv
// rtl/german_rule_sched_if.sv - control, trace-load and rule-select signals of german_rule_sched
interface german_rule_sched_if;
    logic [1:0]  io_mode;
    logic [15:0] io_steps;
    logic        io_start;
    logic        io_stop;
    logic        io_load_valid;
    logic [4:0]  io_load_data;
    logic        io_load_ready;
    logic [4:0]  io_en_a;
    logic        io_busy;
    logic        io_done;
    logic [15:0] io_count;

    modport master (
        output io_mode, io_steps, io_start, io_stop, io_load_valid, io_load_data,
        input  io_load_ready, io_en_a, io_busy, io_done, io_count
    );

    modport slave (
        input  io_mode, io_steps, io_start, io_stop, io_load_valid, io_load_data,
        output io_load_ready, io_en_a, io_busy, io_done, io_count
    );
endinterface

// File: rtl/german_rule_sched.sv
// rtl/german_rule_sched.sv - rule-enable generator driving the German system io_en_a input
module german_rule_sched #(
    parameter int         NUM_RULES = 20,
    parameter int         NOP_CODE  = 31,
    parameter int         DEPTH     = 16,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input logic                clock,
    input logic                reset,
    german_rule_sched_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = PW + 1;

    localparam logic [4:0]    NOP       = 5'(NOP_CODE);
    localparam logic [4:0]    LAST_RULE = 5'(NUM_RULES - 1);
    localparam logic [4:0]    NR        = 5'(NUM_RULES);
    localparam logic [LW-1:0] FULL      = LW'(DEPTH);

    localparam logic [1:0] M_RR     = 2'd0;
    localparam logic [1:0] M_LFSR   = 2'd1;
    localparam logic [1:0] M_REPLAY = 2'd2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic [4:0]    en_q, en_n;
    logic          done_q, done_n;
    logic [15:0]   count_q, count_n;
    logic [1:0]    mode_q, mode_n;
    logic [15:0]   steps_q, steps_n;
    logic [4:0]    rr_q, rr_n;
    logic [LW-1:0] ptr_q, ptr_n;
    logic [7:0]    lfsr_q, lfsr_n;
    logic [LW-1:0] len_q;
    logic [4:0]    trace_q [DEPTH];

    logic [1:0]    src_mode;
    logic [4:0]    src_rr;
    logic [LW-1:0] src_ptr;
    logic [7:0]    src_lfsr;
    logic [4:0]    rule;
    logic          emit;
    logic          load_ready;
    logic          load_acc;
    logic [LW-1:0] eff_len;
    logic          bypass;
    logic          step_limit;
    logic          replay_end;

    assign load_ready = (state == IDLE) && (len_q != FULL);
    assign load_acc   = bus.io_load_valid && load_ready;
    // A start that coincides with a load sees the new entry as part of the trace.
    assign eff_len    = len_q + LW'(load_acc);
    assign bypass     = load_acc && (len_q == '0);
    assign step_limit = (steps_q != 16'd0) && (count_q == steps_q);
    assign replay_end = (mode_q == M_REPLAY) && (ptr_q == len_q);

    assign bus.io_load_ready = load_ready;
    assign bus.io_en_a       = en_q;
    assign bus.io_busy       = (state == RUN);
    assign bus.io_done       = done_q;
    assign bus.io_count      = count_q;

    // Next-state and next-output logic; on start the generators are taken from their restart values.
    always_comb begin
        state_n  = state;
        en_n     = NOP;
        done_n   = 1'b0;
        count_n  = count_q;
        mode_n   = mode_q;
        steps_n  = steps_q;
        rr_n     = rr_q;
        ptr_n    = ptr_q;
        lfsr_n   = lfsr_q;
        src_mode = mode_q;
        src_rr   = rr_q;
        src_ptr  = ptr_q;
        src_lfsr = lfsr_q;
        emit     = 1'b0;
        rule     = NOP;

        if (state == IDLE) begin
            src_mode = (bus.io_mode == 2'd3) ? M_RR : bus.io_mode;
            src_rr   = '0;
            src_ptr  = '0;
            src_lfsr = LFSR_SEED;
        end

        case (src_mode)
            M_LFSR:   rule = (src_lfsr[4:0] < NR) ? src_lfsr[4:0] : NOP;
            M_REPLAY: rule = bypass ? bus.io_load_data : trace_q[src_ptr[PW-1:0]];
            default:  rule = src_rr;
        endcase

        case (state)
            IDLE: begin
                if (bus.io_start) begin
                    mode_n  = src_mode;
                    steps_n = bus.io_steps;
                    count_n = '0;
                    rr_n    = '0;
                    ptr_n   = '0;
                    lfsr_n  = LFSR_SEED;
                    if ((src_mode == M_REPLAY) && (eff_len == '0)) begin
                        done_n = 1'b1;
                    end else begin
                        state_n = RUN;
                        emit    = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.io_stop || step_limit || replay_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    emit = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (emit) begin
            en_n    = rule;
            count_n = (count_n == 16'hFFFF) ? count_n : count_n + 16'd1;
            rr_n    = (src_rr == LAST_RULE) ? 5'd0 : src_rr + 5'd1;
            ptr_n   = src_ptr + LW'(1);
            lfsr_n  = {1'b0, src_lfsr[7:1]} ^ (src_lfsr[0] ? 8'hB8 : 8'h00);
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Output and generator registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_q    <= NOP;
            done_q  <= 1'b0;
            count_q <= '0;
            mode_q  <= M_RR;
            steps_q <= '0;
            rr_q    <= '0;
            ptr_q   <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            en_q    <= en_n;
            done_q  <= done_n;
            count_q <= count_n;
            mode_q  <= mode_n;
            steps_q <= steps_n;
            rr_q    <= rr_n;
            ptr_q   <= ptr_n;
            lfsr_q  <= lfsr_n;
        end
    end

    // Trace buffer: append-only while idle, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                trace_q[i] <= '0;
            end
        end else if (load_acc) begin
            trace_q[len_q[PW-1:0]] <= bus.io_load_data;
            len_q                  <= len_q + LW'(1);
        end
    end
endmodule

// File: tb/tb_german_rule_sched.sv
// tb/tb_german_rule_sched.sv - directed self-checking bench for german_rule_sched
module tb_german_rule_sched;
    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    german_rule_sched_if bus();

    german_rule_sched dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [4:0] trace_val(input int i);
        return 5'((i * 7 + 3) % 32);
    endfunction

    task automatic test_reset();
        checks++;
        if (bus.io_en_a !== 5'd31 || bus.io_busy !== 1'b0 || bus.io_done !== 1'b0 ||
            bus.io_count !== 16'd0 || bus.io_load_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state en=%0d busy=%0b done=%0b count=%0d ready=%0b exp en=31 busy=0 done=0 count=0 ready=1",
                     bus.io_en_a, bus.io_busy, bus.io_done, bus.io_count, bus.io_load_ready);
        end
    endtask

    task automatic test_round_robin();
        bus.io_mode = 2'd0; bus.io_steps = 16'd22; bus.io_start = 1'b1;
        step();
        bus.io_start = 1'b0;
        for (int i = 0; i < 22; i++) begin
            checks++;
            if (bus.io_en_a !== 5'(i % 20) || bus.io_busy !== 1'b1) begin
                errors++;
                $display("FAIL rr_seq i=%0d en=%0d busy=%0b exp en=%0d busy=1", i, bus.io_en_a, bus.io_busy, i % 20);
            end
            step();
        end
        checks++;
        if (bus.io_en_a !== 5'd31 || bus.io_done !== 1'b1 || bus.io_count !== 16'd22 || bus.io_busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_end en=%0d done=%0b count=%0d busy=%0b exp en=31 done=1 count=22 busy=0",
                     bus.io_en_a, bus.io_done, bus.io_count, bus.io_busy);
        end
        step();
        checks++;
        if (bus.io_done !== 1'b0 || bus.io_count !== 16'd22) begin
            errors++;
            $display("FAIL rr_done_pulse done=%0b count=%0d exp done=0 count=22", bus.io_done, bus.io_count);
        end
    endtask

    task automatic test_lfsr();
        logic [4:0] e [10] = '{5'd5, 5'd10, 5'd31, 5'd2, 5'd1, 5'd31, 5'd12, 5'd6, 5'd19, 5'd17};
        bus.io_mode = 2'd1; bus.io_steps = 16'd10; bus.io_start = 1'b1;
        step();
        bus.io_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.io_en_a !== e[i]) begin
                errors++;
                $display("FAIL lfsr_seq i=%0d en=%0d exp=%0d", i, bus.io_en_a, e[i]);
            end
            step();
        end
        checks++;
        if (bus.io_en_a !== 5'd31 || bus.io_done !== 1'b1 || bus.io_count !== 16'd10) begin
            errors++;
            $display("FAIL lfsr_end en=%0d done=%0b count=%0d exp en=31 done=1 count=10",
                     bus.io_en_a, bus.io_done, bus.io_count);
        end
        step();
    endtask

    task automatic test_stop();
        bus.io_mode = 2'd3; bus.io_steps = 16'd0; bus.io_start = 1'b1;
        step();
        bus.io_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.io_en_a !== 5'(i)) begin
                errors++;
                $display("FAIL stop_seq i=%0d en=%0d exp=%0d", i, bus.io_en_a, i);
            end
            if (i == 2) bus.io_start = 1'b1;
            if (i == 4) bus.io_stop = 1'b1;
            step();
            bus.io_start = 1'b0;
        end
        bus.io_stop = 1'b0;
        checks++;
        if (bus.io_en_a !== 5'd31 || bus.io_done !== 1'b1 || bus.io_count !== 16'd5 || bus.io_busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_end en=%0d done=%0b count=%0d busy=%0b exp en=31 done=1 count=5 busy=0",
                     bus.io_en_a, bus.io_done, bus.io_count, bus.io_busy);
        end
        step();
    endtask

    task automatic test_replay_empty(input string tag);
        bus.io_mode = 2'd2; bus.io_steps = 16'd0; bus.io_start = 1'b1;
        step();
        bus.io_start = 1'b0;
        checks++;
        if (bus.io_done !== 1'b1 || bus.io_busy !== 1'b0 || bus.io_en_a !== 5'd31 || bus.io_count !== 16'd0) begin
            errors++;
            $display("FAIL %s done=%0b busy=%0b en=%0d count=%0d exp done=1 busy=0 en=31 count=0",
                     tag, bus.io_done, bus.io_busy, bus.io_en_a, bus.io_count);
        end
        step();
        checks++;
        if (bus.io_done !== 1'b0 || bus.io_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_after done=%0b busy=%0b exp done=0 busy=0", tag, bus.io_done, bus.io_busy);
        end
    endtask

    task automatic test_replay_basic();
        logic [4:0] e [3] = '{5'd3, 5'd0, 5'd8};
        for (int i = 0; i < 3; i++) begin
            bus.io_load_valid = 1'b1; bus.io_load_data = e[i];
            step();
        end
        bus.io_load_valid = 1'b0;
        bus.io_mode = 2'd2; bus.io_steps = 16'd0; bus.io_start = 1'b1;
        step();
        bus.io_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.io_en_a !== e[i] || bus.io_load_ready !== 1'b0) begin
                errors++;
                $display("FAIL replay_seq i=%0d en=%0d ready=%0b exp en=%0d ready=0", i, bus.io_en_a, bus.io_load_ready, e[i]);
            end
            step();
        end
        checks++;
        if (bus.io_en_a !== 5'd31 || bus.io_done !== 1'b1 || bus.io_count !== 16'd3) begin
            errors++;
            $display("FAIL replay_end en=%0d done=%0b count=%0d exp en=31 done=1 count=3",
                     bus.io_en_a, bus.io_done, bus.io_count);
        end
        step();
    endtask

    task automatic test_reset_midrun();
        bus.io_mode = 2'd0; bus.io_steps = 16'd0; bus.io_start = 1'b1;
        step();
        bus.io_start = 1'b0;
        step();
        step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.io_en_a !== 5'd31 || bus.io_busy !== 1'b0 || bus.io_count !== 16'd0) begin
            errors++;
            $display("FAIL async_reset en=%0d busy=%0b count=%0d exp en=31 busy=0 count=0",
                     bus.io_en_a, bus.io_busy, bus.io_count);
        end
        #2 reset = 1'b0;
        checks++;
        if (bus.io_load_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset ready=%0b exp=1", bus.io_load_ready);
        end
        step();
        test_replay_empty("trace_lost");
    endtask

    task automatic test_start_with_load();
        bus.io_mode = 2'd2; bus.io_steps = 16'd0; bus.io_start = 1'b1;
        bus.io_load_valid = 1'b1; bus.io_load_data = 5'd13;
        step();
        bus.io_start = 1'b0; bus.io_load_valid = 1'b0;
        checks++;
        if (bus.io_en_a !== 5'd13 || bus.io_busy !== 1'b1 || bus.io_count !== 16'd1) begin
            errors++;
            $display("FAIL start_load en=%0d busy=%0b count=%0d exp en=13 busy=1 count=1",
                     bus.io_en_a, bus.io_busy, bus.io_count);
        end
        step();
        checks++;
        if (bus.io_en_a !== 5'd31 || bus.io_done !== 1'b1 || bus.io_count !== 16'd1) begin
            errors++;
            $display("FAIL start_load_end en=%0d done=%0b count=%0d exp en=31 done=1 count=1",
                     bus.io_en_a, bus.io_done, bus.io_count);
        end
        step();
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.io_load_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready i=%0d ready=%0b exp=1", i, bus.io_load_ready);
            end
            bus.io_load_valid = 1'b1; bus.io_load_data = trace_val(i);
            step();
        end
        checks++;
        if (bus.io_load_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready ready=%0b exp=0", bus.io_load_ready);
        end
        bus.io_load_data = 5'd0;
        step();
        bus.io_load_valid = 1'b0;
        bus.io_mode = 2'd2; bus.io_steps = 16'd0; bus.io_start = 1'b1;
        step();
        bus.io_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.io_en_a !== trace_val(i)) begin
                errors++;
                $display("FAIL full_seq i=%0d en=%0d exp=%0d", i, bus.io_en_a, trace_val(i));
            end
            step();
        end
        checks++;
        if (bus.io_en_a !== 5'd31 || bus.io_done !== 1'b1 || bus.io_count !== 16'd16) begin
            errors++;
            $display("FAIL full_end en=%0d done=%0b count=%0d exp en=31 done=1 count=16",
                     bus.io_en_a, bus.io_done, bus.io_count);
        end
        step();
        bus.io_steps = 16'd5; bus.io_start = 1'b1;
        step();
        bus.io_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.io_en_a !== trace_val(i)) begin
                errors++;
                $display("FAIL min_seq i=%0d en=%0d exp=%0d", i, bus.io_en_a, trace_val(i));
            end
            step();
        end
        checks++;
        if (bus.io_en_a !== 5'd31 || bus.io_done !== 1'b1 || bus.io_count !== 16'd5) begin
            errors++;
            $display("FAIL min_end en=%0d done=%0b count=%0d exp en=31 done=1 count=5",
                     bus.io_en_a, bus.io_done, bus.io_count);
        end
        step();
    endtask

    initial begin
        reset = 1'b1;
        bus.io_mode = 2'd0; bus.io_steps = 16'd0; bus.io_start = 1'b0; bus.io_stop = 1'b0;
        bus.io_load_valid = 1'b0; bus.io_load_data = 5'd0;
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_round_robin();
        test_lfsr();
        test_stop();
        test_replay_empty("replay_empty");
        test_replay_basic();
        test_reset_midrun();
        test_start_with_load();
        test_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
